// File: rtl/multicycle_controller_if.sv
// Bundle between the multicycle controller and its datapath: decoded instruction
// fields and status flags in, datapath/memory strobes out.
interface multicycle_controller_if #(
  parameter int ALUCTRL_W = 3
);
  logic [5:0]           op;
  logic [5:0]           funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 iord;
  logic                 memread;
  logic                 memwrite;
  logic                 irwrite;
  logic                 pcen;
  logic                 alusrca;
  logic [1:0]           alusrcb;
  logic [1:0]           pcsrc;
  logic                 regdst;
  logic                 memtoreg;
  logic                 regwrite;
  logic                 signext;
  logic                 shiftl16;
  logic                 link;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic [3:0]           state;
  logic                 instr_done;
  logic                 illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, memread, memwrite, irwrite, pcen, alusrca, alusrcb, pcsrc,
           regdst, memtoreg, regwrite, signext, shiftl16, link, alucontrol,
           state, instr_done, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, memread, memwrite, irwrite, pcen, alusrca, alusrcb, pcsrc,
           regdst, memtoreg, regwrite, signext, shiftl16, link, alucontrol,
           state, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main FSM of the multicycle MIPS core: steps each instruction from FETCH through
// writeback, with memory wait states, bne/jal/jr and illegal-opcode trapping.
module multicycle_controller #(
  parameter int ALUCTRL_W    = 3,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BRANCH  = 4'd8,
    ITYPEEX = 4'd9,
    ITYPEWB = 4'd10,
    JUMP    = 4'd11,
    JAL     = 4'd12,
    JR      = 4'd13,
    TRAP    = 4'd14
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b010);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b110);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b000);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b001);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b111);

  state_t state, next;

  logic                 funct_alu_ok;
  logic [ALUCTRL_W-1:0] funct_alu;
  logic                 bad_instr;

  logic iord_s, memread_s, memwrite_s, irwrite_s, pcen_s, alusrca_s;
  logic regdst_s, memtoreg_s, regwrite_s, signext_s, shiftl16_s, link_s;
  logic instr_done_s, illegal_s;
  logic [1:0] alusrcb_s, pcsrc_s;
  logic [ALUCTRL_W-1:0] alucontrol_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= next;
  end

  always_comb begin
    funct_alu_ok = 1'b1;
    funct_alu    = ALU_ADD;
    case (bus.funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    next         = state;
    bad_instr    = 1'b0;
    iord_s       = 1'b0;
    memread_s    = 1'b0;
    memwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    pcen_s       = 1'b0;
    alusrca_s    = 1'b0;
    alusrcb_s    = 2'b00;
    pcsrc_s      = 2'b00;
    regdst_s     = 1'b0;
    memtoreg_s   = 1'b0;
    regwrite_s   = 1'b0;
    signext_s    = 1'b0;
    shiftl16_s   = 1'b0;
    link_s       = 1'b0;
    alucontrol_s = ALU_ADD;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    case (state)
      FETCH: begin
        memread_s = 1'b1;
        alusrcb_s = 2'b01;
        if (bus.mem_ready) begin
          irwrite_s = 1'b1;
          pcen_s    = 1'b1;
          next      = DECODE;
        end
      end
      DECODE: begin
        // ALU precomputes the branch target into ALUOut while op is decoded
        alusrcb_s = 2'b11;
        signext_s = 1'b1;
        case (bus.op)
          OP_R: begin
            if (funct_alu_ok)           next = RTYPEEX;
            else if (bus.funct == FN_JR) next = JR;
            else                         bad_instr = 1'b1;
          end
          OP_LW, OP_SW:           next = MEMADR;
          OP_BEQ, OP_BNE:         next = BRANCH;
          OP_ADDI, OP_ORI, OP_LUI: next = ITYPEEX;
          OP_J:                   next = JUMP;
          OP_JAL:                 next = JAL;
          default:                bad_instr = 1'b1;
        endcase
        if (bad_instr) begin
          illegal_s = !TRAP_ILLEGAL;
          next      = TRAP_ILLEGAL ? TRAP : FETCH;
        end
      end
      MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        signext_s = 1'b1;
        next      = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord_s    = 1'b1;
        memread_s = 1'b1;
        if (bus.mem_ready) next = MEMWB;
      end
      MEMWB: begin
        regwrite_s   = 1'b1;
        memtoreg_s   = 1'b1;
        instr_done_s = 1'b1;
        next         = FETCH;
      end
      MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
        if (bus.mem_ready) begin
          instr_done_s = 1'b1;
          next         = FETCH;
        end
      end
      RTYPEEX: begin
        alusrca_s    = 1'b1;
        alucontrol_s = funct_alu;
        next         = RTYPEWB;
      end
      RTYPEWB: begin
        regdst_s     = 1'b1;
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
        next         = FETCH;
      end
      BRANCH: begin
        alusrca_s    = 1'b1;
        alucontrol_s = ALU_SUB;
        pcsrc_s      = 2'b01;
        pcen_s       = bus.zero ^ (bus.op == OP_BNE);
        instr_done_s = 1'b1;
        next         = FETCH;
      end
      ITYPEEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        case (bus.op)
          OP_ORI:  alucontrol_s = ALU_OR;
          OP_LUI: begin
            shiftl16_s   = 1'b1;
            alucontrol_s = ALU_OR;
          end
          default: signext_s = 1'b1;
        endcase
        next = ITYPEWB;
      end
      ITYPEWB: begin
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
        next         = FETCH;
      end
      JUMP: begin
        pcsrc_s      = 2'b10;
        pcen_s       = 1'b1;
        instr_done_s = 1'b1;
        next         = FETCH;
      end
      JAL: begin
        pcsrc_s      = 2'b10;
        pcen_s       = 1'b1;
        link_s       = 1'b1;
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
        next         = FETCH;
      end
      JR: begin
        pcsrc_s      = 2'b11;
        pcen_s       = 1'b1;
        instr_done_s = 1'b1;
        next         = FETCH;
      end
      TRAP: begin
        illegal_s = 1'b1;
        next      = TRAP;
      end
      default: next = FETCH;
    endcase
  end

  // State-changing strobes are gated by reset so nothing fires while reset_n is held low
  assign bus.memread    = memread_s    & reset_n;
  assign bus.memwrite   = memwrite_s   & reset_n;
  assign bus.irwrite    = irwrite_s    & reset_n;
  assign bus.pcen       = pcen_s       & reset_n;
  assign bus.regwrite   = regwrite_s   & reset_n;
  assign bus.instr_done = instr_done_s & reset_n;
  assign bus.illegal    = illegal_s    & reset_n;

  assign bus.iord       = iord_s;
  assign bus.alusrca    = alusrca_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.pcsrc      = pcsrc_s;
  assign bus.regdst     = regdst_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.signext    = signext_s;
  assign bus.shiftl16   = shiftl16_s;
  assign bus.link       = link_s;
  assign bus.alucontrol = alucontrol_s;
  assign bus.state      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: two instances (trapping and non-trapping
// illegal handling) share stimulus; expected values are hand-derived per cycle.
module tb_multicycle_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  logic clk;
  logic reset_n;
  int unsigned n_checks;
  int unsigned n_pass;

  multicycle_controller_if #(.ALUCTRL_W(3)) bus0 ();
  multicycle_controller_if #(.ALUCTRL_W(3)) bus1 ();

  multicycle_controller #(.ALUCTRL_W(3), .TRAP_ILLEGAL(1'b1)) dut_trap (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  multicycle_controller #(.ALUCTRL_W(3), .TRAP_ILLEGAL(1'b0)) dut_pulse (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] op, input logic [5:0] funct,
                       input logic zero, input logic ready);
    bus0.op = op; bus0.funct = funct; bus0.zero = zero; bus0.mem_ready = ready;
    bus1.op = op; bus1.funct = funct; bus1.zero = zero; bus1.mem_ready = ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(OP_LW, 6'd0, 1'b0, 1'b1);
    tick();
    #1;
    n_checks++; if (bus0.state !== 4'd0) $display("FAIL rst_state got %0d exp 0", bus0.state); else n_pass++;
    n_checks++;
    if ({bus0.memread, bus0.memwrite, bus0.irwrite, bus0.pcen, bus0.regwrite, bus0.instr_done, bus0.illegal} !== 7'b0)
      $display("FAIL rst_strobes got %b exp 0000000",
               {bus0.memread, bus0.memwrite, bus0.irwrite, bus0.pcen, bus0.regwrite, bus0.instr_done, bus0.illegal});
    else n_pass++;
    n_checks++; if (bus0.alusrcb !== 2'b01) $display("FAIL rst_alusrcb got %b exp 01", bus0.alusrcb); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++; if (bus0.memread !== 1'b1 || bus0.state !== 4'd0)
      $display("FAIL rst_release got memread=%b state=%0d exp 1/0", bus0.memread, bus0.state); else n_pass++;
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    int unsigned done_cnt = 0;
    drive(OP_LW, 6'd0, 1'b0, 1'b0);
    n_checks++; if ({bus0.memread, bus0.irwrite, bus0.pcen} !== 3'b100)
      $display("FAIL fetch_stall got %b exp 100", {bus0.memread, bus0.irwrite, bus0.pcen}); else n_pass++;
    tick();
    n_checks++; if (bus0.state !== 4'd0) $display("FAIL fetch_hold got %0d exp 0", bus0.state); else n_pass++;
    drive(OP_LW, 6'd0, 1'b0, 1'b1);
    n_checks++; if ({bus0.irwrite, bus0.pcen} !== 2'b11)
      $display("FAIL fetch_go got %b exp 11", {bus0.irwrite, bus0.pcen}); else n_pass++;
    done_cnt += bus0.instr_done;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus0.state !== exp_s[i]) $display("FAIL lw_state%0d got %0d exp %0d", i, bus0.state, exp_s[i]); else n_pass++;
      done_cnt += bus0.instr_done;
    end
    n_checks++; if ({bus0.regwrite, bus0.memtoreg, bus0.regdst} !== 3'b110)
      $display("FAIL lw_wb got %b exp 110", {bus0.regwrite, bus0.memtoreg, bus0.regdst}); else n_pass++;
    tick();
    n_checks++; if (bus0.state !== 4'd0) $display("FAIL lw_end got %0d exp 0", bus0.state); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL lw_done_pulses got %0d exp 1", done_cnt); else n_pass++;
  endtask

  task automatic test_sw_wait();
    drive(OP_SW, 6'd0, 1'b0, 1'b1);
    tick(); tick(); tick();
    drive(OP_SW, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({bus0.state, bus0.memwrite, bus0.iord, bus0.instr_done, bus0.memread} !== {4'd5, 4'b1100})
        $display("FAIL sw_wait%0d got state=%0d mw=%b iord=%b done=%b mr=%b exp 5/1/1/0/0", i,
                 bus0.state, bus0.memwrite, bus0.iord, bus0.instr_done, bus0.memread);
      else n_pass++;
      tick();
    end
    drive(OP_SW, 6'd0, 1'b0, 1'b1);
    n_checks++; if ({bus0.state, bus0.memwrite, bus0.iord, bus0.instr_done} !== {4'd5, 3'b111})
      $display("FAIL sw_last got state=%0d mw=%b iord=%b done=%b exp 5/1/1/1",
               bus0.state, bus0.memwrite, bus0.iord, bus0.instr_done); else n_pass++;
    tick();
    n_checks++; if (bus0.state !== 4'd0) $display("FAIL sw_end got %0d exp 0", bus0.state); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    drive(OP_SW, 6'd0, 1'b0, 1'b1);
    tick(); tick(); tick();
    drive(OP_SW, 6'd0, 1'b0, 1'b0);
    tick();
    n_checks++; if (bus0.memwrite !== 1'b1) $display("FAIL midwr_pre got %b exp 1", bus0.memwrite); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({bus0.memwrite, bus0.memread, bus0.state} !== {2'b00, 4'd0})
      $display("FAIL midwr_abort got mw=%b mr=%b state=%0d exp 0/0/0", bus0.memwrite, bus0.memread, bus0.state); else n_pass++;
    tick();
    reset_n = 1'b1;
    drive(OP_SW, 6'd0, 1'b0, 1'b1);
    n_checks++; if ({bus0.memread, bus0.state} !== {1'b1, 4'd0})
      $display("FAIL midwr_release got mr=%b state=%0d exp 1/0", bus0.memread, bus0.state); else n_pass++;
  endtask

  task automatic test_branch();
    drive(OP_BEQ, 6'd0, 1'b1, 1'b1);
    tick(); tick();
    n_checks++; if ({bus0.state, bus0.pcen, bus0.pcsrc, bus0.instr_done, bus0.alucontrol} !== {4'd8, 1'b1, 2'b01, 1'b1, 3'b110})
      $display("FAIL beq_taken got state=%0d pcen=%b pcsrc=%b done=%b alu=%b exp 8/1/01/1/110",
               bus0.state, bus0.pcen, bus0.pcsrc, bus0.instr_done, bus0.alucontrol); else n_pass++;
    tick();
    drive(OP_BNE, 6'd0, 1'b1, 1'b1);
    tick(); tick();
    n_checks++; if (bus0.pcen !== 1'b0) $display("FAIL bne_zero1 got pcen=%b exp 0", bus0.pcen); else n_pass++;
    drive(OP_BNE, 6'd0, 1'b0, 1'b1);
    n_checks++; if (bus0.pcen !== 1'b1) $display("FAIL bne_zero0 got pcen=%b exp 1", bus0.pcen); else n_pass++;
    tick();
    n_checks++; if (bus0.state !== 4'd0) $display("FAIL branch_end got %0d exp 0", bus0.state); else n_pass++;
  endtask

  task automatic test_jumps();
    drive(OP_JAL, 6'd0, 1'b0, 1'b1);
    tick();
    n_checks++; if (bus0.state !== 4'd1) $display("FAIL jal_decode got %0d exp 1", bus0.state); else n_pass++;
    tick();
    n_checks++; if ({bus0.state, bus0.pcen, bus0.link, bus0.regwrite, bus0.pcsrc} !== {4'd12, 3'b111, 2'b10})
      $display("FAIL jal got state=%0d pcen=%b link=%b rw=%b pcsrc=%b exp 12/1/1/1/10",
               bus0.state, bus0.pcen, bus0.link, bus0.regwrite, bus0.pcsrc); else n_pass++;
    tick();
    drive(OP_R, 6'b001000, 1'b0, 1'b1);
    tick(); tick();
    n_checks++; if ({bus0.state, bus0.pcsrc, bus0.pcen, bus0.regwrite} !== {4'd13, 2'b11, 2'b10})
      $display("FAIL jr got state=%0d pcsrc=%b pcen=%b rw=%b exp 13/11/1/0",
               bus0.state, bus0.pcsrc, bus0.pcen, bus0.regwrite); else n_pass++;
    tick();
  endtask

  task automatic test_alu_ops();
    drive(OP_R, 6'b100010, 1'b0, 1'b1);
    tick(); tick();
    n_checks++; if ({bus0.state, bus0.alucontrol, bus0.alusrca, bus0.alusrcb} !== {4'd6, 3'b110, 1'b1, 2'b00})
      $display("FAIL rsub_ex got state=%0d alu=%b a=%b b=%b exp 6/110/1/00",
               bus0.state, bus0.alucontrol, bus0.alusrca, bus0.alusrcb); else n_pass++;
    tick();
    n_checks++; if ({bus0.state, bus0.regdst, bus0.regwrite} !== {4'd7, 2'b11})
      $display("FAIL rtype_wb got state=%0d rd=%b rw=%b exp 7/1/1", bus0.state, bus0.regdst, bus0.regwrite); else n_pass++;
    tick();
    drive(OP_R, 6'b101010, 1'b0, 1'b1);
    tick(); tick();
    n_checks++; if (bus0.alucontrol !== 3'b111) $display("FAIL rslt got %b exp 111", bus0.alucontrol); else n_pass++;
    tick(); tick();
    drive(OP_ORI, 6'd0, 1'b0, 1'b1);
    tick(); tick();
    n_checks++; if ({bus0.state, bus0.alucontrol, bus0.shiftl16, bus0.signext, bus0.alusrcb} !== {4'd9, 3'b001, 2'b00, 2'b10})
      $display("FAIL ori_ex got state=%0d alu=%b sh=%b se=%b b=%b exp 9/001/0/0/10",
               bus0.state, bus0.alucontrol, bus0.shiftl16, bus0.signext, bus0.alusrcb); else n_pass++;
    tick();
    n_checks++; if ({bus0.state, bus0.regwrite, bus0.regdst} !== {4'd10, 2'b10})
      $display("FAIL itype_wb got state=%0d rw=%b rd=%b exp 10/1/0", bus0.state, bus0.regwrite, bus0.regdst); else n_pass++;
    tick();
    drive(OP_LUI, 6'd0, 1'b0, 1'b1);
    tick(); tick();
    n_checks++; if ({bus0.shiftl16, bus0.alucontrol} !== {1'b1, 3'b001})
      $display("FAIL lui_ex got sh=%b alu=%b exp 1/001", bus0.shiftl16, bus0.alucontrol); else n_pass++;
    tick(); tick();
  endtask

  task automatic test_illegal();
    drive(6'b111111, 6'd0, 1'b0, 1'b1);
    tick();
    n_checks++; if ({bus1.state, bus1.illegal} !== {4'd1, 1'b1})
      $display("FAIL illpulse_decode got state=%0d ill=%b exp 1/1", bus1.state, bus1.illegal); else n_pass++;
    tick();
    n_checks++; if ({bus1.state, bus1.illegal} !== {4'd0, 1'b0})
      $display("FAIL illpulse_after got state=%0d ill=%b exp 0/0", bus1.state, bus1.illegal); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({bus0.state, bus0.illegal, bus0.memread, bus0.memwrite, bus0.irwrite, bus0.pcen, bus0.regwrite, bus0.instr_done}
          !== {4'd14, 7'b1000000})
        $display("FAIL trap%0d got state=%0d ill=%b strobes=%b exp 14/1/000000", i, bus0.state, bus0.illegal,
                 {bus0.memread, bus0.memwrite, bus0.irwrite, bus0.pcen, bus0.regwrite, bus0.instr_done});
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_reset_mid_write();
    test_branch();
    test_jumps();
    test_alu_ops();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
